// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pseudo-random generator.
//   state_t : generator FSM states (filling a word / holding a finished word)
//   TAPS_*  : maximal-length Galois tap masks for common register lengths
package lfsr_pkg;

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

endpackage

// File: rtl/lfsr_step.sv
// One combinational Galois LFSR step.
//   cur : current shift register value
//   nxt : value after one step
//   b   : emitted bit (the LSB shifted out)
module lfsr_step #(
  parameter int              LEN  = 8,
  parameter logic [LEN-1:0]  TAPS = '0
) (
  input  logic [LEN-1:0] cur,
  output logic [LEN-1:0] nxt,
  output logic           b
);

  assign b   = cur[0];
  assign nxt = {1'b0, cur[LEN-1:1]} ^ (b ? TAPS : '0);

endmodule

// File: rtl/lfsr_prng.sv
// Galois-LFSR random word generator with valid/ready output and seed handshake.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : advance enable (pauses a partially filled word when low)
//   seed_valid  : seed offer; seed_ready = ~out_valid | out_ready
//   seed        : new register value, zero selects DEFAULT_SEED
//   out_valid   : out_data holds a complete word; out_ready accepts it
//   out_data    : random word, first generated bit in [0]
//   lockup_err  : sticky, set when the all-zero state was seen and repaired
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int             LEN          = 8,
  parameter logic [LEN-1:0] TAPS         = LEN'(TAPS_8),
  parameter logic [LEN-1:0] DEFAULT_SEED = {LEN{1'b1}},
  parameter int             STEPS        = 1,
  parameter int             OUT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_valid,
  input  logic [LEN-1:0]   seed,
  output logic             seed_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             lockup_err
);

  localparam int CW = $clog2(OUT_W + 1);

  if (STEPS < 1 || STEPS > OUT_W || (OUT_W % STEPS) != 0) begin : g_bad_steps
    $error("lfsr_prng: STEPS must be in 1..OUT_W and divide OUT_W");
  end
  if (LEN < 2 || OUT_W < 2) begin : g_bad_size
    $error("lfsr_prng: LEN and OUT_W must be at least 2");
  end

  state_t           state;
  logic [LEN-1:0]   sreg;
  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] pk;

  // STEPS chained single steps; chain[i] is the register after i steps
  logic [STEPS:0][LEN-1:0] chain;
  logic [STEPS-1:0]        bits;

  assign chain[0] = sreg;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    lfsr_step #(.LEN(LEN), .TAPS(TAPS)) u_step (
      .cur(chain[i]),
      .nxt(chain[i+1]),
      .b  (bits[i])
    );
  end

  // Packer: each new bit enters at the MSB so the oldest bit ends up in [0]
  logic [OUT_W-1:0] pk_n;
  always_comb begin
    pk_n = pk;
    for (int i = 0; i < STEPS; i++) pk_n = {bits[i], pk_n[OUT_W-1:1]};
  end

  logic [CW-1:0] cnt_n;
  logic          acc, seed_ld, lock, run;

  assign cnt_n      = cnt + CW'(STEPS);
  assign seed_ready = ~out_valid | out_ready;
  assign acc        = out_valid & out_ready;
  assign seed_ld    = seed_valid & seed_ready;
  assign lock       = (sreg == '0);
  // A handshake edge also starts the next word, keeping full throughput
  assign run        = en & ((state == S_FILL) | acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FILL;
      sreg       <= DEFAULT_SEED;
      cnt        <= '0;
      pk         <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      lockup_err <= 1'b0;
    end else begin
      if (acc) begin
        out_valid <= 1'b0;
        state     <= S_FILL;
      end
      // Priority: seed load, then lock-up repair, then normal stepping
      if (seed_ld) begin
        sreg       <= (seed != '0) ? seed : DEFAULT_SEED;
        cnt        <= '0;
        pk         <= '0;
        lockup_err <= 1'b0;
      end else if (lock) begin
        sreg       <= DEFAULT_SEED;
        lockup_err <= 1'b1;
      end else if (run) begin
        sreg <= chain[STEPS];
        pk   <= pk_n;
        if (cnt_n == CW'(OUT_W)) begin
          cnt       <= '0;
          out_data  <= pk_n;
          out_valid <= 1'b1;
          state     <= S_HOLD;
        end else begin
          cnt <= cnt_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: three instances (STEPS=1, STEPS=8, and a
// zero-tap register that walks into the all-zero state) share one stimulus and
// are shadowed cycle by cycle by a behavioural model.
module tb_lfsr_prng;

  logic clk = 1'b0;
  logic rst, en, seed_valid, out_ready;
  logic [7:0] seed;
  logic [2:0] ov, sr, le;
  logic [2:0][7:0] od, sg;

  always #5 clk = ~clk;

  lfsr_prng #(.LEN(8), .TAPS(8'hB8), .DEFAULT_SEED(8'hFF), .STEPS(1), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .seed_valid(seed_valid), .seed(seed),
    .seed_ready(sr[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .lockup_err(le[0]));

  lfsr_prng #(.LEN(8), .TAPS(8'hB8), .DEFAULT_SEED(8'hFF), .STEPS(8), .OUT_W(8)) d8 (
    .clk(clk), .rst(rst), .en(en), .seed_valid(seed_valid), .seed(seed),
    .seed_ready(sr[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .lockup_err(le[1]));

  lfsr_prng #(.LEN(8), .TAPS(8'h00), .DEFAULT_SEED(8'hFF), .STEPS(1), .OUT_W(8)) dz (
    .clk(clk), .rst(rst), .en(en), .seed_valid(seed_valid), .seed(seed),
    .seed_ready(sr[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .lockup_err(le[2]));

  assign sg[0] = dut.sreg;
  assign sg[1] = d8.sreg;
  assign sg[2] = dz.sreg;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Word-level view: a word is "held" exactly while ov is set; bits are
  // collected by index into acc and published when eight have arrived.
  typedef struct {
    logic [7:0] s;
    int         cnt;
    logic [7:0] acc;
    bit         ov;
    logic [7:0] dat;
    bit         lerr;
  } mst_t;

  mst_t       m [3];
  logic [7:0] tp [3] = '{8'hB8, 8'hB8, 8'h00};
  int         st [3] = '{1, 8, 1};

  function automatic mst_t mreset();
    mst_t r;
    r.s = 8'hFF; r.cnt = 0; r.acc = 8'h00; r.ov = 0; r.dat = 8'h00; r.lerr = 0;
    return r;
  endfunction

  function automatic mst_t mstep(mst_t mi, logic [7:0] taps, int steps,
                                 bit e, bit v, logic [7:0] sd, bit r);
    mst_t mo = mi;
    bit taken = mi.ov && r;
    bit b;
    if (taken) mo.ov = 0;
    if (v && (!mi.ov || r)) begin
      mo.s = (sd != 8'h00) ? sd : 8'hFF;
      mo.cnt = 0; mo.acc = 8'h00; mo.lerr = 0;
    end else if (mi.s == 8'h00) begin
      mo.s = 8'hFF; mo.lerr = 1;
    end else if ((!mi.ov || taken) && e) begin
      for (int k = 0; k < steps; k++) begin
        b = mo.s[0];
        mo.s = 8'(mo.s / 2) ^ (b ? taps : 8'h00);
        mo.acc[mo.cnt] = b;
        mo.cnt++;
      end
      if (mo.cnt == 8) begin
        mo.dat = mo.acc; mo.ov = 1; mo.cnt = 0; mo.acc = 8'h00;
      end
    end
    return mo;
  endfunction

  task automatic cmp_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.out_valid", i), 32'(ov[i]), 32'(m[i].ov));
      chk($sformatf("u%0d.out_data", i), 32'(od[i]), 32'(m[i].dat));
      chk($sformatf("u%0d.lockup_err", i), 32'(le[i]), 32'(m[i].lerr));
      chk($sformatf("u%0d.seed_ready", i), 32'(sr[i]), 32'(!m[i].ov || out_ready));
      chk($sformatf("u%0d.sreg", i), 32'(sg[i]), 32'(m[i].s));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      m[i] = mstep(m[i], tp[i], st[i], en, seed_valid, seed, out_ready);
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) m[i] = mreset();
    #1;
    cmp_all();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         en, rdy, sv;
    logic [7:0] sd;
    bit         ev;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(bit e, bit r, bit v, logic [7:0] sd, bit ev, logic [7:0] ed);
    vec_t x;
    x.en = e; x.rdy = r; x.sv = v; x.sd = sd; x.ev = ev; x.ed = ed;
    return x;
  endfunction

  bit stream [2040];

  initial begin
    int nb, mism, cyc;
    int divs [7] = '{1, 3, 5, 15, 17, 51, 85};

    rst = 1'b1; en = 1'b0; seed_valid = 1'b0; seed = 8'h00; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) m[i] = mreset();

    // First word 8 edges after release, then a zero seed mid-word, then seed FF
    for (int k = 1; k <= 7; k++) tbl.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 1, 0, 8'h00, 1, 8'h2F));
    for (int k = 9; k <= 11; k++) tbl.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 1, 1, 8'h00, 0, 8'h00));
    for (int k = 13; k <= 19; k++) tbl.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 1, 0, 8'h00, 1, 8'h2F));
    tbl.push_back(mk(1, 1, 1, 8'hFF, 0, 8'h00));
    for (int k = 22; k <= 28; k++) tbl.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 1, 0, 8'h00, 1, 8'h2F));

    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(ov[0]), 32'd0);
    chk("reset.out_data", 32'(od[0]), 32'd0);
    chk("reset.lockup_err", 32'(le[0]), 32'd0);
    chk("reset.sreg", 32'(sg[0]), 32'hFF);
    rst = 1'b0;

    foreach (tbl[k]) begin
      en = tbl[k].en; out_ready = tbl[k].rdy; seed_valid = tbl[k].sv; seed = tbl[k].sd;
      tick();
      chk($sformatf("tbl%0d.valid", k), 32'(ov[0]), 32'(tbl[k].ev));
      if (tbl[k].ev) chk($sformatf("tbl%0d.data", k), 32'(od[0]), 32'(tbl[k].ed));
      if (k == 7) chk("tbl.sreg_after_word", 32'(sg[0]), 32'h23);
    end
    chk("first_word_sreg", 32'(sg[0]), 32'h23);

    // Consumer stalls 20 cycles; a seed offer meanwhile must be refused
    en = 1'b1; out_ready = 1'b0; seed_valid = 1'b1; seed = 8'h55;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("hold.valid", 32'(ov[0]), 32'd1);
      chk("hold.data", 32'(od[0]), 32'h2F);
      chk("hold.seed_ready", 32'(sr[0]), 32'd0);
      chk("hold.sreg", 32'(sg[0]), 32'h23);
    end
    seed_valid = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("release.edge%0d", k), 32'(ov[0]), 32'(k == 8));
    end

    // STEPS=8 word on the first edge, then one per cycle; zero-tap lock-up
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) chk("d8.first_word", 32'(od[1]), 32'h2F);
      if (k <= 5) chk("d8.back_to_back", 32'(ov[1]), 32'd1);
      if (k == 8) chk("dz.zero_state", 32'(sg[2]), 32'h00);
      if (k == 8) chk("dz.no_err_yet", 32'(le[2]), 32'd0);
      if (k == 9) chk("dz.recovered", 32'(sg[2]), 32'hFF);
      if (k == 9) chk("dz.lockup_err", 32'(le[2]), 32'd1);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("dz.sticky", 32'(le[2]), 32'd1);
    end
    seed_valid = 1'b1; seed = 8'h80;
    tick();
    seed_valid = 1'b0;
    chk("dz.seed_clears", 32'(le[2]), 32'd0);
    chk("dz.seed_value", 32'(sg[2]), 32'h80);

    // Reset asserted while a word is being held
    out_ready = 1'b0;
    cyc = 0;
    while (!ov[0] && cyc < 20) begin tick(); cyc++; end
    chk("midhold.reached", 32'(ov[0]), 32'd1);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) m[i] = mreset();
    #1;
    cmp_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // Free-run the STEPS=1 generator and check the bit-stream period
    en = 1'b1; out_ready = 1'b1; seed_valid = 1'b0;
    nb = 0; cyc = 0;
    while (nb < 2040 && cyc < 3000) begin
      tick();
      cyc++;
      if (sg[0] == 8'h00) chk("freerun.nonzero", 32'(sg[0]), 32'h1);
      if (ov[0]) for (int j = 0; j < 8; j++) begin stream[nb] = od[0][j]; nb++; end
    end
    chk("freerun.bits_collected", 32'(nb), 32'd2040);
    mism = 0;
    for (int i = 0; i < 2040 - 255; i++) if (stream[i] != stream[i+255]) mism++;
    chk("period255", 32'(mism), 32'd0);
    foreach (divs[d]) begin
      mism = 0;
      for (int i = 0; i < 255; i++) if (stream[i] != stream[i+divs[d]]) mism++;
      chk($sformatf("no_period_%0d", divs[d]), 32'(mism != 0), 32'd1);
    end

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      seed_valid = ($urandom % 16) == 0;
      seed = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
